pwm_speed_selector: RTL

Upstream control stage for `PWM_module`. Turns three raw push-buttons (up, down, stop) into the `enable` and `speed[2:0]` inputs the PWM generator consumes. Includes input synchronisation, debouncing, a saturating target-speed register and a soft-start ramp, so the PWM duty never jumps more than one level at a time except on an emergency stop. Sits between the top-level `ui_in` pins and `PWM_module`.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/pwm_speed_selector.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM speed-control path.
package pwm_pkg;

  localparam int unsigned SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } ramp_state_e;

  function automatic speed_t sat_inc(input speed_t v);
    return (v == SPEED_MAX) ? v : v + speed_t'(1);
  endfunction

  function automatic speed_t sat_dec(input speed_t v);
    return (v == '0) ? v : v - speed_t'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            r_stable;
  logic            r_press;
  logic [CntW-1:0] r_cnt;
  logic            w_diff;

  assign w_diff = r_sync[1] ^ r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync  <= {r_sync[0], raw};
      r_press <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        // Accept the new level; pulse only on a rising acceptance.
        r_cnt    <= '0;
        r_stable <= ~r_stable;
        r_press  <= ~r_stable;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign level = r_stable;
  assign press = r_press;

endmodule

// File: rtl/pwm_speed_selector.sv
// Button-driven target speed with a one-level-per-period soft-start ramp toward it.
module pwm_speed_selector
  import pwm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RAMP_CYCLES     = 1024
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_up,
  input  logic   btn_down,
  input  logic   btn_stop,
  output logic   enable,
  output speed_t speed,
  output speed_t target,
  output logic   busy
);

  localparam int unsigned TmrW = $clog2(RAMP_CYCLES);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(RAMP_CYCLES - 1);

  logic w_up_press, w_down_press, w_stop_press, w_stop_level;
  logic w_unused_up_level, w_unused_down_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (w_unused_up_level),
    .press (w_up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .level (w_unused_down_level),
    .press (w_down_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_stop),
    .level (w_stop_level),
    .press (w_stop_press)
  );

  speed_t          r_speed, r_target, w_speed_d, w_target_d;
  ramp_state_e     r_state, w_state_d, w_dir;
  logic [TmrW-1:0] r_timer, w_timer_d;
  logic            w_dir_up;

  always_comb begin
    w_target_d = r_target;
    if (w_stop_press) begin
      w_target_d = '0;
    end else if (w_stop_level || (w_up_press && w_down_press)) begin
      w_target_d = r_target;
    end else if (w_up_press) begin
      w_target_d = sat_inc(r_target);
    end else if (w_down_press) begin
      w_target_d = sat_dec(r_target);
    end
  end

  assign w_dir_up = (r_target > r_speed);
  assign w_dir    = w_dir_up ? UP : DOWN;

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_speed_d = r_speed;
    unique case (r_state)
      IDLE: begin
        w_timer_d = '0;
        if (r_speed != r_target) begin
          w_state_d = w_dir;
          w_timer_d = TmrW'(1);
        end
      end
      UP, DOWN: begin
        if (r_speed == r_target) begin
          w_state_d = IDLE;
          w_timer_d = '0;
        end else begin
          // Direction follows target every cycle; the timer keeps running across reversals.
          w_state_d = w_dir;
          if (r_timer == TmrMax) begin
            w_timer_d = '0;
            w_speed_d = w_dir_up ? r_speed + speed_t'(1) : r_speed - speed_t'(1);
          end else begin
            w_timer_d = r_timer + TmrW'(1);
          end
        end
      end
      default: begin
        w_state_d = IDLE;
        w_timer_d = '0;
      end
    endcase
    if (w_stop_press) begin
      w_state_d = IDLE;
      w_timer_d = '0;
      w_speed_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_speed  <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_d;
      r_timer  <= w_timer_d;
      r_speed  <= w_speed_d;
      r_target <= w_target_d;
    end
  end

  assign speed  = r_speed;
  assign target = r_target;
  assign enable = (r_speed != '0);
  assign busy   = (r_speed != r_target);

endmodule
